// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared types and widths for the seven-segment scan controller.
package sevenseg_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Control/display bundle between a host and the scan controller.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import sevenseg_pkg::*;

    logic                             enable;
    logic                             load;
    logic [NIBBLE_W*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]            blank_mask;
    logic [NUM_DIGITS-1:0]            digit_en;
    logic [NIBBLE_W-1:0]              seg_data;
    logic [SEG_W-1:0]                 segments;
    logic                             frame_done;

    modport master (
        output enable, load, value_in, blank_mask,
        input  digit_en, seg_data, segments, frame_done
    );

    modport slave (
        input  enable, load, value_in, blank_mask,
        output digit_en, seg_data, segments, frame_done
    );

endinterface

// File: rtl/sevenseg_scan_ctrl_sevenseg.sv
// Hex nibble to seven-segment decoder, segments = {g,f,e,d,c,b,a}, active-high.
module sevenseg
    import sevenseg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_o
);

    // Full hex glyph table (0-9, A, b, C, d, E, F).
    always_comb begin
        seg_o = 7'h00;
        case (nibble_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: blank gap per slot, one shared
// decoder, and a shadow/display pair so new values appear only between frames.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sevenseg_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic [NIBBLE_W-1:0]   seg_data_q;
    logic                  frame_done_q;

    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [VAL_W-1:0]      display_q, display_d;
    logic                  pending_q, pending_d;

    logic [NUM_DIGITS-1:0] idx_onehot;
    logic                  frame_end;

    assign idx_onehot = NUM_DIGITS'(1) << idx_q;
    // Last cycle of the last digit's SHOW phase: the frame commit point.
    assign frame_end  = bus.enable && (state_q == SHOW) &&
                        (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

    // Scan FSM, slot counter, digit index and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            digit_en_q   <= '0;
            seg_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else if (!bus.enable) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_q      <= '0;
                        state_q    <= SHOW;
                        seg_data_q <= display_q[idx_q*NIBBLE_W +: NIBBLE_W];
                        digit_en_q <= idx_onehot & ~bus.blank_mask;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_q        <= '0;
                        state_q      <= BLANK;
                        digit_en_q   <= '0;
                        idx_q        <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        frame_done_q <= (idx_q == IDX_LAST);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Double buffer: loads land in shadow, display swaps only at frame end
    // (or right away while scanning is disabled). A load in the commit cycle
    // goes straight to display.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (!bus.enable) begin
            if (pending_q) begin
                display_d = shadow_q;
                pending_d = 1'b0;
            end
        end else if (frame_end) begin
            if (bus.load)
                display_d = bus.value_in;
            else if (pending_q)
                display_d = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d = bus.value_in;
            if (!frame_end)
                pending_d = 1'b1;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
        end
    end

    sevenseg u_dec (
        .nibble_i (seg_data_q),
        .seg_o    (bus.segments)
    );

    assign bus.digit_en   = digit_en_q;
    assign bus.seg_data   = seg_data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl: directed scenarios plus random
// traffic against a time-indexed reference model.
module tb_sevenseg_scan_ctrl;
    import sevenseg_pkg::*;

    localparam int N  = 4;
    localparam int RD = 10;
    localparam int BC = 2;
    localparam int FRAME = N * RD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: t = index of the current cycle since the scan (re)started.
    int          t;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend;
    logic [3:0]  e_en;
    logic [3:0]  e_seg;
    bit          e_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        t = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
        e_en = '0; e_seg = '0; e_fd = 0;
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    function automatic void model_edge();
        int ph, slot;
        bit last;
        if (!bus.enable) begin
            e_en = '0;
            e_fd = 0;
            if (m_pend) begin m_disp = m_shadow; m_pend = 0; end
            if (bus.load) begin m_shadow = bus.value_in; m_pend = 1; end
            t = 0;
            return;
        end
        ph   = t % RD;
        slot = (t / RD) % N;
        last = (ph == RD - 1) && (slot == N - 1);
        e_fd = last;
        if (ph == BC - 1) begin
            e_seg = 4'((m_disp >> (4 * slot)) & 16'hF);
            e_en  = (4'b0001 << slot) & ~bus.blank_mask;
        end
        if (ph == RD - 1) e_en = '0;
        if (last) begin
            if (bus.load) m_disp = bus.value_in;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 0;
            if (bus.load) m_shadow = bus.value_in;
        end else if (bus.load) begin
            m_shadow = bus.value_in;
            m_pend   = 1;
        end
        t++;
    endfunction

    task automatic check_out();
        chk("digit_en",   32'(bus.digit_en),   32'(e_en));
        chk("seg_data",   32'(bus.seg_data),   32'(e_seg));
        chk("segments",   32'(bus.segments),   32'(SEG_TAB[e_seg]));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (reset) model_reset();
            else       model_edge();
            #1;
            check_out();
        end
    endtask

    // Run until the model is in frame cycle p (enable must be high).
    task automatic wait_phase(input int p);
        int guard = 0;
        while ((t % FRAME) != p && guard < 3 * FRAME) begin
            step(1);
            guard++;
        end
        if (guard >= 3 * FRAME) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_phase: phase %0d not reached, t=%0d", p, t);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.load = 1'b1; bus.value_in = v;
        step(1);
        bus.load = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.enable = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.blank_mask = '0;

        // Reset state, then free-running scan of an all-zero value.
        step(2);
        reset = 1'b0;
        step(FRAME + 5);

        // Load 1234 while disabled, then scan it out.
        bus.enable = 1'b0;
        step(1);
        pulse_load(16'h1234);
        step(1);
        bus.enable = 1'b1;
        step(2 * FRAME);

        // Mid-frame load is held until the frame boundary.
        wait_phase(15);
        pulse_load(16'hABCD);
        step(2 * FRAME);

        // Mask digit 3; frame timing unchanged.
        bus.blank_mask = 4'b1000;
        step(2 * FRAME);
        bus.blank_mask = 4'b0000;

        // Load in the commit cycle bypasses a pending value.
        wait_phase(10);
        pulse_load(16'hABCD);
        bus.value_in = 16'h0;
        wait_phase(FRAME - 1);
        pulse_load(16'h5678);
        step(FRAME + 5);

        // Asynchronous reset in the middle of digit 2's SHOW phase.
        wait_phase(25);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_digit_en",   32'(bus.digit_en),   32'h0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
        chk("rst_seg_data",   32'(bus.seg_data),   32'h0);
        step(2);
        reset = 1'b0;
        step(FRAME + 5);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.enable   = ($urandom_range(0, 29) != 0);
            bus.load     = ($urandom_range(0, 14) == 0);
            bus.value_in = 16'($urandom);
            if ($urandom_range(0, 49) == 0) bus.blank_mask = 4'($urandom);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit seven-segment display.
- Shares one `sevenseg` decoder across NUM_DIGITS digits: selects one 4-bit nibble per time slot, drives the decoder, and asserts the matching one-hot digit enable.
- Inserts a blanking gap between slots to suppress ghosting.
- Double-buffers the displayed value so updates take effect only at frame boundaries (tear-free).

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- REFRESH_DIV, 1000: clk cycles per digit slot (blank + show).
- BLANK_CYCLES, 8: cycles at the start of each slot with all digits off; requires 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; 0 forces all digits off.
- load  in  1  one-cycle strobe; captures value_in.
- value_in  in  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0].
- blank_mask  in  NUM_DIGITS  1 = keep that digit dark during its slot.
- digit_en  out  NUM_DIGITS  registered one-hot digit enable, active-high.
- seg_data  out  4  registered nibble currently routed to the decoder.
- segments  out  7  combinational `sevenseg` output for seg_data.
- frame_done  out  1  registered one-cycle pulse at end of the last digit's slot.

Behaviour:
- Reset (async, immediate): digit_en=0, seg_data=0, frame_done=0, idx=0, cnt=0, state=BLANK, shadow=0, display=0, pending=0.
- FSM states:
  - BLANK: digit_en=0; cnt runs 0..BLANK_CYCLES-1, then cnt<=0 and state<=SHOW.
  - SHOW: cnt runs 0..REFRESH_DIV-BLANK_CYCLES-1, then cnt<=0, state<=BLANK, idx<=idx+1 (NUM_DIGITS-1 wraps to 0).
- Output registers:
  - seg_data <= display[4*idx +: 4], updated on the BLANK->SHOW transition.
  - digit_en <= one-hot(idx) & ~blank_mask[idx], registered, so it asserts in the first SHOW cycle and deasserts in the first BLANK cycle.
  - seg_data is stable for the whole SHOW phase.
- blank_mask is sampled at the BLANK->SHOW edge. A masked digit keeps digit_en=0 for its full slot; slot timing is unchanged.
- Load handling: on load=1, shadow<=value_in and pending<=1. Multiple loads within a frame: the last one wins.
- Commit occurs on the SHOW->BLANK edge with idx=NUM_DIGITS-1:
  - frame_done=1 for exactly one cycle.
  - If pending: display<=shadow, pending<=0.
  - If load=1 in that same cycle: display<=value_in directly and pending<=0 (load bypasses the shadow).
- enable=0 (synchronous):
  - Next cycle: state=BLANK, cnt=0, idx=0, digit_en=0, frame_done=0.
  - A pending value commits immediately (display<=shadow); a load while disabled reaches display one cycle later.
- enable 0->1: the scan starts at digit 0, BLANK phase, cnt=0.
- Counter width: $clog2(REFRESH_DIV). idx width: $clog2(NUM_DIGITS), minimum 1. No other arithmetic; all counts are unsigned and non-saturating.

Decomposition:
- Package `sevenseg_pkg`:
  - scan_state_t enum {BLANK, SHOW}.
  - NIBBLE_W=4, SEG_W=7 constants.
- One sub-module: the existing `sevenseg` decoder, instantiated once (seg_data -> segments).
- Counter, FSM and buffers stay flat in sevenseg_scan_ctrl.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=10, BLANK_CYCLES=2.
- Reset with enable=1, then release -> cycles 0-1 digit_en=0000; cycles 2-9 digit_en=0001, seg_data=0; cycle 12 digit_en=0010; pattern repeats every 40 cycles.
- enable=0, load value_in=16'h1234, then enable=1 -> slots show seg_data 4,3,2,1 with digit_en 0001,0010,0100,1000; segments match the `sevenseg` model each cycle.
- Running with 16'h1234, load 16'hABCD during digit 1's SHOW -> digits 2,3 still show 2,1; frame_done pulses at cycle 39 of the frame; the next frame shows D,C,B,A.
- blank_mask=4'b1000 -> digit 3 slot has digit_en=0000 for all 10 cycles, frame period stays 40, frame_done timing is unchanged.
- Assert reset mid-SHOW of digit 2 -> digit_en=0000 and frame_done=0 in the same cycle; after release, the scan restarts at digit 0 showing 0.
- load=1 with value_in=16'h5678 exactly in the frame_done cycle, with 16'hABCD pending -> the next frame shows 8,7,6,5 and pending=0.
